// File: rtl/program_memory_pkg.sv
// Shared definitions for the instruction path: word geometry, the no-op word,
// and the program-memory phase encoding used by the PC and the decoder.
package program_memory_pkg;

  localparam int unsigned word_size  = 16;
  localparam int unsigned addr_width = 8;
  localparam int unsigned depth      = 2 ** addr_width;

  localparam logic [word_size-1:0] nop_word  = 16'h0000;
  localparam logic [word_size-1:0] zero_word = '0;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/program_memory_array.sv
// Single-port synchronous RAM holding the program.
// The read register is cleared by reset; the storage itself is not.
module program_memory_array
  import program_memory_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [addr_width-1:0] address,
  input  logic [word_size-1:0]  write_data,
  output logic [word_size-1:0]  read_data
);

  logic [word_size-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem[address] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data <= zero_word;
    end else if (read_enable) begin
      read_data <= mem[address];
    end
  end

endmodule

// File: rtl/program_memory.sv
// Instruction store with a LOAD phase (host writes words) and a RUN phase
// (one fetch answered per request, one cycle later). Phase FSM and fault live here.
module program_memory
  import program_memory_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [word_size-1:0]  address,
  input  logic                  fetch_enable,
  output logic [word_size-1:0]  instruction,
  output logic                  instruction_valid,
  input  logic                  prog_enable,
  input  logic [addr_width-1:0] prog_address,
  input  logic [word_size-1:0]  prog_data,
  output logic                  prog_ack,
  input  logic                  prog_done,
  input  logic                  reload,
  output logic                  busy,
  output logic                  fault,
  output state_e                fsm_state
);

  // Strobe semantics: prog_enable and fetch_enable are single-cycle requests
  // sampled at the rising edge; the responder always accepts, and prog_ack /
  // instruction_valid pulse for exactly one cycle in the cycle after acceptance.

  state_e               state_q, state_d;
  logic                 write_go, fetch_go, fetch_bad, read_go;
  logic [addr_width-1:0] ram_address;
  logic [word_size-1:0] ram_data;
  logic                 use_nop_q, valid_q, ack_q, fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (prog_done) state_d = RUN;
      RUN:     if (reload)    state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // A fetch coinciding with reload is dropped; X/Z detection is simulation-only.
  assign write_go    = (state_q == LOAD) && prog_enable;
  assign fetch_go    = (state_q == RUN) && fetch_enable && !reload;
  assign fetch_bad   = $isunknown(address) || (|address[word_size-1:addr_width]);
  assign read_go     = fetch_go && !fetch_bad;
  assign ram_address = write_go ? prog_address : address[addr_width-1:0];

  program_memory_array u_array (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_go),
    .read_enable  (read_go),
    .address      (ram_address),
    .write_data   (prog_data),
    .read_data    (ram_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      use_nop_q <= 1'b0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      valid_q <= fetch_go;
      ack_q   <= write_go;
      if (fetch_go) begin
        use_nop_q <= fetch_bad;
      end
      if (fetch_go && fetch_bad) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign instruction       = use_nop_q ? nop_word : ram_data;
  assign instruction_valid = valid_q;
  assign prog_ack          = ack_q;
  assign fault             = fault_q;
  assign busy              = (state_q == LOAD);
  assign fsm_state         = state_q;

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: load, fetch, fault, ignored strobes,
// reload and asynchronous reset, with hand-computed expectations.
module tb_program_memory;
  import program_memory_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [word_size-1:0]  address;
  logic                  fetch_enable;
  logic [word_size-1:0]  instruction;
  logic                  instruction_valid;
  logic                  prog_enable;
  logic [addr_width-1:0] prog_address;
  logic [word_size-1:0]  prog_data;
  logic                  prog_ack;
  logic                  prog_done;
  logic                  reload;
  logic                  busy;
  logic                  fault;
  state_e                fsm_state;

  int checks = 0;
  int errors = 0;
  bit four_state;

  logic [word_size-1:0] load_data [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [word_size-1:0] fetch_addr [6] = '{16'h0004, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0003};
  logic [word_size-1:0] fetch_exp  [6] = '{16'h5555, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h4444};

  program_memory dut (
    .clk               (clk),
    .reset             (reset),
    .address           (address),
    .fetch_enable      (fetch_enable),
    .instruction       (instruction),
    .instruction_valid (instruction_valid),
    .prog_enable       (prog_enable),
    .prog_address      (prog_address),
    .prog_data         (prog_data),
    .prog_ack          (prog_ack),
    .prog_done         (prog_done),
    .reload            (reload),
    .busy              (busy),
    .fault             (fault),
    .fsm_state         (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; address = '0; fetch_enable = 1'b0; prog_enable = 1'b0;
    prog_address = '0; prog_data = '0; prog_done = 1'b0; reload = 1'b0;
    #3;
    checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL reset_instruction got=%h exp=0000", instruction); end
    checks++; if (instruction_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instruction_valid); end
    checks++; if (prog_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", prog_ack); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (fsm_state !== LOAD) begin errors++; $display("FAIL reset_state got=%0d exp=LOAD", fsm_state); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load();
    // fetch_enable held high to confirm it is ignored while loading
    fetch_enable = 1'b1; address = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      prog_enable = 1'b1; prog_address = 8'(i); prog_data = load_data[i];
      tick();
      checks++; if (prog_ack !== 1'b1) begin errors++; $display("FAIL load_ack[%0d] got=%b exp=1", i, prog_ack); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy[%0d] got=%b exp=1", i, busy); end
      checks++; if (instruction_valid !== 1'b0) begin errors++; $display("FAIL load_valid[%0d] got=%b exp=0", i, instruction_valid); end
    end
    prog_enable = 1'b0; fetch_enable = 1'b0;
    tick();
    checks++; if (prog_ack !== 1'b0) begin errors++; $display("FAIL load_ack_idle got=%b exp=0", prog_ack); end
    checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL load_instr_hold got=%h exp=0000", instruction); end
  endtask

  task automatic test_done_with_write();
    prog_enable = 1'b1; prog_address = 8'd4; prog_data = 16'h5555; prog_done = 1'b1;
    tick();
    prog_enable = 1'b0; prog_done = 1'b0;
    checks++; if (prog_ack !== 1'b1) begin errors++; $display("FAIL done_write_ack got=%b exp=1", prog_ack); end
    checks++; if (fsm_state !== RUN) begin errors++; $display("FAIL done_state got=%0d exp=RUN", fsm_state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back_fetch();
    for (int i = 0; i < 6; i++) begin
      address = fetch_addr[i]; fetch_enable = 1'b1;
      tick();
      checks++; if (instruction !== fetch_exp[i]) begin errors++; $display("FAIL fetch_data[%0d] got=%h exp=%h", i, instruction, fetch_exp[i]); end
      checks++; if (instruction_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid[%0d] got=%b exp=1", i, instruction_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fetch_busy[%0d] got=%b exp=0", i, busy); end
    end
    fetch_enable = 1'b0;
    tick();
    checks++; if (instruction_valid !== 1'b0) begin errors++; $display("FAIL fetch_idle_valid got=%b exp=0", instruction_valid); end
    checks++; if (instruction !== 16'h4444) begin errors++; $display("FAIL fetch_idle_hold got=%h exp=4444", instruction); end
  endtask

  task automatic test_z_address();
    address = 'z; fetch_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instruction !== 16'h4444) begin errors++; $display("FAIL z_idle_hold[%0d] got=%h exp=4444", i, instruction); end
      checks++; if (instruction_valid !== 1'b0) begin errors++; $display("FAIL z_idle_valid[%0d] got=%b exp=0", i, instruction_valid); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL z_idle_fault[%0d] got=%b exp=0", i, fault); end
    end
    fetch_enable = 1'b1;
    tick();
    fetch_enable = 1'b0;
    checks++; if (instruction_valid !== 1'b1) begin errors++; $display("FAIL z_fetch_valid got=%b exp=1", instruction_valid); end
    // a two-state simulator cannot carry Z into the design, so only check nop/fault where it can
    if (four_state) begin
      checks++; if (instruction !== nop_word) begin errors++; $display("FAIL z_fetch_nop got=%h exp=%h", instruction, nop_word); end
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL z_fetch_fault got=%b exp=1", fault); end
    end
    address = 16'h0000;
  endtask

  task automatic test_write_in_run();
    prog_enable = 1'b1; prog_address = 8'd0; prog_data = 16'hDEAD;
    tick();
    prog_enable = 1'b0;
    checks++; if (prog_ack !== 1'b0) begin errors++; $display("FAIL run_write_ack got=%b exp=0", prog_ack); end
    address = 16'h0000; fetch_enable = 1'b1;
    tick();
    fetch_enable = 1'b0;
    checks++; if (instruction !== 16'h1111) begin errors++; $display("FAIL run_write_kept got=%h exp=1111", instruction); end
  endtask

  task automatic test_out_of_range();
    address = 16'h0100; fetch_enable = 1'b1;
    tick();
    checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL oor_nop got=%h exp=0000", instruction); end
    checks++; if (instruction_valid !== 1'b1) begin errors++; $display("FAIL oor_valid got=%b exp=1", instruction_valid); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL oor_fault got=%b exp=1", fault); end
    address = 16'h0001;
    tick();
    checks++; if (instruction !== 16'h2222) begin errors++; $display("FAIL oor_recover got=%h exp=2222", instruction); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL oor_sticky got=%b exp=1", fault); end
    address = 16'hFF02;
    tick();
    checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL oor_high_nop got=%h exp=0000", instruction); end
    address = 16'h0002;
    tick();
    fetch_enable = 1'b0;
    checks++; if (instruction !== 16'h3333) begin errors++; $display("FAIL oor_after got=%h exp=3333", instruction); end
  endtask

  task automatic test_reload();
    address = 16'h0001; fetch_enable = 1'b1; reload = 1'b1;
    tick();
    fetch_enable = 1'b0; reload = 1'b0;
    checks++; if (instruction_valid !== 1'b0) begin errors++; $display("FAIL reload_drop_valid got=%b exp=0", instruction_valid); end
    checks++; if (instruction !== 16'h3333) begin errors++; $display("FAIL reload_hold got=%h exp=3333", instruction); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reload_busy got=%b exp=1", busy); end
    prog_enable = 1'b1; prog_address = 8'd5; prog_data = 16'h6666;
    tick();
    prog_enable = 1'b0; prog_done = 1'b1;
    tick();
    prog_done = 1'b0;
    address = 16'h0005; fetch_enable = 1'b1;
    tick();
    fetch_enable = 1'b0;
    checks++; if (instruction !== 16'h6666) begin errors++; $display("FAIL reload_new_word got=%h exp=6666", instruction); end
  endtask

  task automatic test_reset_mid_fetch();
    address = 16'h0000; fetch_enable = 1'b1;
    tick();
    fetch_enable = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (instruction !== 16'h0000) begin errors++; $display("FAIL async_instr got=%h exp=0000", instruction); end
    checks++; if (instruction_valid !== 1'b0) begin errors++; $display("FAIL async_valid got=%b exp=0", instruction_valid); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL async_fault got=%b exp=0", fault); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL async_busy got=%b exp=1", busy); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++; if (fsm_state !== LOAD) begin errors++; $display("FAIL post_reset_state got=%0d exp=LOAD", fsm_state); end
    prog_done = 1'b1;
    tick();
    prog_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_run got=%b exp=0", busy); end
    address = 16'h0001; fetch_enable = 1'b1;
    tick();
    fetch_enable = 1'b0;
    checks++; if (instruction !== 16'h2222) begin errors++; $display("FAIL post_reset_mem got=%h exp=2222", instruction); end
    checks++; if (instruction_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid got=%b exp=1", instruction_valid); end
  endtask

  initial begin
    logic probe;
    probe = 1'bz;
    four_state = $isunknown(probe);
    test_reset();
    test_load();
    test_done_with_write();
    test_back_to_back_fetch();
    test_z_address();
    test_write_in_run();
    test_out_of_range();
    test_reload();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
